// File: rtl/snn_syn_pkg.sv
// Shared definitions for the synaptic update engine.
//   - Update FSM state encoding (IDLE=0, RD=1, MOD=2, WB=3)
//   - Default weight lane width and lane count for a 32-bit word
//   - Signed saturation limits for a default-width lane
package snn_syn_pkg;

  localparam int W_WIDTH    = 8;
  localparam int WORD_WIDTH = 32;
  localparam int LANES      = WORD_WIDTH / W_WIDTH;

  localparam logic signed [W_WIDTH-1:0] SAT_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH-1:0] SAT_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MOD  = 2'd2,
    ST_WB   = 2'd3
  } upd_state_e;

endpackage

// File: rtl/syn_lane_add.sv
// Single-lane signed weight update: res = old_w + delta.
// The add is carried at W+1 bits so overflow is visible.
// Overflow handling is selected by the SYN_UPD_SAT_EN macro:
//   defined   -> clamp to [-2^(W-1), 2^(W-1)-1]
//   undefined -> two's-complement wrap (keep low W bits)
// Ports:
//   old_w  in  W  current lane weight
//   delta  in  W  signed delta
//   res    out W  updated lane weight
module syn_lane_add
  import snn_syn_pkg::*;
#(
  parameter int W = W_WIDTH
) (
  input  logic [W-1:0] old_w,
  input  logic [W-1:0] delta,
  output logic [W-1:0] res
);

  logic signed [W:0] sum;

  assign sum = $signed({old_w[W-1], old_w}) + $signed({delta[W-1], delta});

`ifdef SYN_UPD_SAT_EN
  // Overflow shows up as the two top bits of the widened sum disagreeing;
  // the top bit then tells the direction to clamp.
  always_comb begin
    res = sum[W-1:0];
    if (sum[W] != sum[W-1])
      res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  logic unused_carry;
  assign unused_carry = sum[W];
  assign res          = sum[W-1:0];
`endif

endmodule

// File: rtl/synaptic_update_engine.sv
// Read-modify-write engine owning the synaptic SRAM port.
// Inference reads always win the port; learning updates are serialised
// through an IDLE -> RD -> MOD -> WB FSM and stall in RD/WB while an
// inference read is present. No forwarding: an inference read of a word
// mid-update returns the pre-update value.
// Optional feature macro: SYN_UPD_SAT_EN (lane saturation instead of wrap).
// Ports:
//   CK, RST_N              clock, async active-low reset
//   upd_valid/ready        update handshake; upd_addr, upd_delta payload
//   inf_req, inf_addr      inference read request
//   inf_valid, inf_data    inference read response (1-cycle latency)
//   sram_CS/WE/A/D, sram_Q SRAM port (Q registered, 1-cycle latency)
//   busy                   FSM not idle
//   upd_cnt                completed write-backs, wrapping
module synaptic_update_engine
  import snn_syn_pkg::upd_state_e;
  import snn_syn_pkg::ST_IDLE;
  import snn_syn_pkg::ST_RD;
  import snn_syn_pkg::ST_MOD;
  import snn_syn_pkg::ST_WB;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TOTAL_DEPTH = 12544,
  parameter int W_WIDTH     = snn_syn_pkg::W_WIDTH,
  parameter int CNT_WIDTH   = 16,
  localparam int ADDR_W     = $clog2(TOTAL_DEPTH),
  localparam int LANES      = DATA_WIDTH / W_WIDTH
) (
  input  logic                  CK,
  input  logic                  RST_N,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_W-1:0]     upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_delta,
  input  logic                  inf_req,
  input  logic [ADDR_W-1:0]     inf_addr,
  output logic                  inf_valid,
  output logic [DATA_WIDTH-1:0] inf_data,
  output logic                  sram_CS,
  output logic                  sram_WE,
  output logic [ADDR_W-1:0]     sram_A,
  output logic [DATA_WIDTH-1:0] sram_D,
  input  logic [DATA_WIDTH-1:0] sram_Q,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  upd_cnt
);

  upd_state_e state, nxt;

  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] delta_q;
  logic [DATA_WIDTH-1:0] wbuf;
  logic [DATA_WIDTH-1:0] lane_res;
  logic [ADDR_W-1:0]     a_hold;
  logic [DATA_WIDTH-1:0] d_hold;
  logic [ADDR_W-1:0]     a_cur;
  logic                  eng_rd, eng_wr;
  logic [1:0]            vld_pipe;

  // ---------------- lane adders ----------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    syn_lane_add #(.W(W_WIDTH)) u_lane (
      .old_w (sram_Q [k*W_WIDTH +: W_WIDTH]),
      .delta (delta_q[k*W_WIDTH +: W_WIDTH]),
      .res   (lane_res[k*W_WIDTH +: W_WIDTH])
    );
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    eng_rd = 1'b0;
    eng_wr = 1'b0;
    case (state)
      ST_IDLE: if (upd_valid) nxt = ST_RD;
      ST_RD:   if (!inf_req) begin eng_rd = 1'b1; nxt = ST_MOD; end
      ST_MOD:  nxt = ST_WB;
      ST_WB:   if (!inf_req) begin eng_wr = 1'b1; nxt = ST_IDLE; end
      default: nxt = ST_IDLE;
    endcase
  end

  assign upd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // ---------------- SRAM port ----------------
  // The port is driven combinationally from the current state so a read
  // issued in RD lands in sram_Q during MOD. A/D keep their last driven
  // values on idle cycles via the hold registers.
  assign a_cur   = inf_req ? inf_addr : addr_q;
  assign sram_CS = inf_req | eng_rd | eng_wr;
  assign sram_WE = eng_wr;
  assign sram_A  = sram_CS ? a_cur : a_hold;
  assign sram_D  = eng_wr  ? wbuf  : d_hold;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      a_hold <= '0;
      d_hold <= '0;
    end else begin
      if (sram_CS) a_hold <= a_cur;
      if (eng_wr)  d_hold <= wbuf;
    end
  end

  // ---------------- datapath / counters ----------------
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q  <= '0;
      delta_q <= '0;
      wbuf    <= '0;
      upd_cnt <= '0;
    end else begin
      if (state == ST_IDLE && upd_valid) begin
        addr_q  <= upd_addr;
        delta_q <= upd_delta;
      end
      if (state == ST_MOD) wbuf <= lane_res;
      if (eng_wr)          upd_cnt <= upd_cnt + 1'b1;
    end
  end

  // ---------------- inference response ----------------
  assign vld_pipe[0] = inf_req;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  end

  assign inf_valid = vld_pipe[1];
  assign inf_data  = sram_Q;

endmodule

// File: tb/tb_synaptic_update_engine.sv
// Directed, table-driven bench for synaptic_update_engine with a
// behavioural 1-cycle-latency SRAM. CNT_WIDTH is reduced to 4 so the
// counter wrap is reachable in a short run.
module tb_synaptic_update_engine;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          CK = 1'b0;
  logic          RST_N;
  logic          upd_valid;
  logic          upd_ready;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_delta;
  logic          inf_req;
  logic [AW-1:0] inf_addr;
  logic          inf_valid;
  logic [DW-1:0] inf_data;
  logic          sram_CS, sram_WE;
  logic [AW-1:0] sram_A;
  logic [DW-1:0] sram_D;
  logic [DW-1:0] sram_Q = 32'hDEADBEEF;
  logic          busy;
  logic [3:0]    upd_cnt;

  logic [DW-1:0] mem [0:12543];

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] exp_cnt;

  synaptic_update_engine #(.CNT_WIDTH(4)) dut (
    .CK(CK), .RST_N(RST_N),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .upd_delta(upd_delta),
    .inf_req(inf_req), .inf_addr(inf_addr),
    .inf_valid(inf_valid), .inf_data(inf_data),
    .sram_CS(sram_CS), .sram_WE(sram_WE), .sram_A(sram_A),
    .sram_D(sram_D), .sram_Q(sram_Q),
    .busy(busy), .upd_cnt(upd_cnt)
  );

  initial forever #5 CK = ~CK;

  // SRAM model: registered read, write on CS&WE.
  always @(posedge CK) begin
    if (sram_CS) begin
      if (sram_WE) mem[sram_A] = sram_D;
      else         sram_Q <= mem[sram_A];
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Returns just after the accepting edge T.
  task automatic start_upd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int i;
    for (i = 0; i < 50 && !upd_ready; i++) tick();
    if (!upd_ready) chk("ready_timeout", 32'(upd_ready), 32'd1);
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_delta = d;
    tick();
    upd_valid = 1'b0;
  endtask

  // Edges taken until the FSM is back in IDLE.
  task automatic finish_upd(output int edges);
    edges = 0;
    while (busy && edges < 50) begin
      tick();
      edges++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] old_w;
    logic [DW-1:0] delta;
    logic [DW-1:0] exp_w;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e;
    RST_N = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_delta = '0;
    inf_req = 1'b0; inf_addr = '0;
    exp_cnt = '0;

    vecs[0] = '{14'd5,     32'h01020304, 32'h01FF0102, 32'h02010406};
`ifdef SYN_UPD_SAT_EN
    vecs[1] = '{14'd6,     32'h0000007F, 32'h00000005, 32'h0000007F};
    vecs[2] = '{14'd7,     32'h00000080, 32'h000000FF, 32'h00000080};
    vecs[3] = '{14'd8,     32'h7F801234, 32'h01010101, 32'h7F811335};
    vecs[4] = '{14'd9,     32'h80FF0010, 32'hFFFF8001, 32'h80FE8011};
`else
    vecs[1] = '{14'd6,     32'h0000007F, 32'h00000005, 32'h00000084};
    vecs[2] = '{14'd7,     32'h00000080, 32'h000000FF, 32'h0000007F};
    vecs[3] = '{14'd8,     32'h7F801234, 32'h01010101, 32'h80811335};
    vecs[4] = '{14'd9,     32'h80FF0010, 32'hFFFF8001, 32'h7FFE8011};
`endif
    vecs[5] = '{14'd12543, 32'hFFFFFFFF, 32'h01010101, 32'h00000000};

    // ---- reset state ----
    tick(); tick();
    chk("rst_ready",   32'(upd_ready), 32'd1);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_infv",    32'(inf_valid), 32'd0);
    chk("rst_cs",      32'(sram_CS),   32'd0);
    chk("rst_we",      32'(sram_WE),   32'd0);
    chk("rst_a",       32'(sram_A),    32'd0);
    chk("rst_d",       sram_D,         32'd0);
    chk("rst_cnt",     32'(upd_cnt),   32'd0);
    chk("rst_infdata", inf_data,       32'hDEADBEEF);
    RST_N = 1'b1;
    tick();

    // ---- reset during MOD: write dropped ----
    mem[40] = 32'h55555555;
    start_upd(14'd40, 32'h01010101);
    tick();
    chk("mod_busy", 32'(busy), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rmod_ready", 32'(upd_ready), 32'd1);
    chk("rmod_busy",  32'(busy),      32'd0);
    chk("rmod_cnt",   32'(upd_cnt),   32'd0);
    chk("rmod_cs",    32'(sram_CS),   32'd0);
    tick(); tick();
    RST_N = 1'b1;
    tick(); tick(); tick();
    chk("rmod_mem",   mem[40],        32'h55555555);
    chk("rmod_cnt2",  32'(upd_cnt),   32'd0);

    // ---- table-driven updates ----
    for (int i = 0; i < 6; i++) begin
      mem[vecs[i].addr] = vecs[i].old_w;
      start_upd(vecs[i].addr, vecs[i].delta);
      finish_upd(e);
      exp_cnt++;
      chk($sformatf("v%0d_lat", i),  32'(e),         32'd3);
      chk($sformatf("v%0d_mem", i),  mem[vecs[i].addr], vecs[i].exp_w);
      chk($sformatf("v%0d_cnt", i),  32'(upd_cnt),   32'(exp_cnt));
      chk($sformatf("v%0d_cs", i),   32'(sram_CS),   32'd0);
      chk($sformatf("v%0d_ahold", i), 32'(sram_A),   32'(vecs[i].addr));
      chk($sformatf("v%0d_dhold", i), sram_D,        vecs[i].exp_w);
    end

    // ---- contention: inf_req held 3 cycles while in RD ----
    mem[10] = 32'h11223344;
    mem[20] = 32'hAABBCCDD;
    mem[21] = 32'h0BADF00D;
    mem[22] = 32'hC0FFEE00;
    start_upd(14'd10, 32'h01010101);
    inf_req = 1'b1; inf_addr = 14'd20;
    tick();
    chk("ct_v0",  32'(inf_valid), 32'd1);
    chk("ct_d0",  inf_data,       32'hAABBCCDD);
    chk("ct_rdy", 32'(upd_ready), 32'd0);
    inf_addr = 14'd21;
    tick();
    chk("ct_v1",  32'(inf_valid), 32'd1);
    chk("ct_d1",  inf_data,       32'h0BADF00D);
    inf_addr = 14'd22;
    tick();
    chk("ct_v2",  32'(inf_valid), 32'd1);
    chk("ct_d2",  inf_data,       32'hC0FFEE00);
    inf_req = 1'b0;
    finish_upd(e);
    exp_cnt++;
    chk("ct_lat", 32'(e + 3),     32'd6);
    chk("ct_mem", mem[10],        32'h12233445);
    chk("ct_cnt", 32'(upd_cnt),   32'(exp_cnt));

    // ---- hazard: inference read during MOD sees old word ----
    mem[30] = 32'h10203040;
    start_upd(14'd30, 32'h01010101);
    tick();
    inf_req = 1'b1; inf_addr = 14'd30;
    tick();
    inf_req = 1'b0;
    chk("hz_v",   32'(inf_valid), 32'd1);
    chk("hz_old", inf_data,       32'h10203040);
    finish_upd(e);
    exp_cnt++;
    chk("hz_lat", 32'(e),         32'd1);
    inf_req = 1'b1; inf_addr = 14'd30;
    tick();
    inf_req = 1'b0;
    chk("hz_new", inf_data,       32'h11213141);
    chk("hz_cnt", 32'(upd_cnt),   32'(exp_cnt));

    // ---- counter wrap (CNT_WIDTH=4) ----
    for (int i = 0; i < 7; i++) begin
      start_upd(14'd100, 32'h00000001);
      finish_upd(e);
    end
    chk("wrap_15", 32'(upd_cnt), 32'd15);
    start_upd(14'd100, 32'h00000001);
    finish_upd(e);
    chk("wrap_0",  32'(upd_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
